// File: rtl/pipe_addsub.sv
// Two-stage pipelined adder/subtractor with valid/ready handshake, optional
// saturation, and a saturating counter of delivered overflowing results.
module pipe_addsub #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          op,
    input  logic          sgn,
    input  logic          sat,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y,
    output logic          cout,
    output logic          ovf,
    output logic [CW-1:0] ovf_cnt,
    input  logic          clr_cnt
);

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic         s1_op;
    logic         s1_sgn;
    logic         s1_sat;

    logic         s1_adv;
    logic         s2_adv;

    logic [W-1:0] b_eff;
    logic [W:0]   sum;
    logic [W-1:0] y_raw;
    logic         c_raw;
    logic         v_sgn;
    logic         v_sel;
    logic [W-1:0] y_nxt;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Subtraction is a + ~b + 1; the carry-out then means "no borrow".
    always_comb begin
        b_eff = s1_op ? ~s1_b : s1_b;
        sum   = {1'b0, s1_a} + {1'b0, b_eff} + (W+1)'(s1_op);
        y_raw = sum[W-1:0];
        c_raw = sum[W] ^ s1_op;
        v_sgn = (s1_a[W-1] == b_eff[W-1]) && (y_raw[W-1] != s1_a[W-1]);
        v_sel = s1_sgn ? v_sgn : c_raw;
        y_nxt = y_raw;
        if (s1_sat && v_sel) begin
            if (!s1_sgn)
                y_nxt = s1_op ? '0 : '1;
            else if (s1_a[W-1])
                y_nxt = {1'b1, {(W-1){1'b0}}};
            else
                y_nxt = {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_sat   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_op  <= op;
                s1_sgn <= sgn;
                s1_sat <= sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y    <= y_nxt;
                cout <= c_raw;
                ovf  <= v_sel;
            end
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt)
            ovf_cnt <= '0;
        else if (out_valid && out_ready && ovf && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + CW'(1);
    end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the operand and result width in bits (W >= 2).
REQ-002 The block SHALL have parameter CW, default 8, giving the overflow-counter width in bits.
REQ-003 The block SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block accepts operand set this cycle.
- a  in  W  first operand.
- b  in  W  second operand.
- op  in  1  0 = a+b, 1 = a-b.
- sgn  in  1  1 = two's-complement interpretation, 0 = unsigned.
- sat  in  1  1 = saturate result on overflow.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- y  out  W  result.
- cout  out  1  add: carry-out; sub: borrow (unsigned a < b).
- ovf  out  1  overflow flag for the selected interpretation.
- ovf_cnt  out  CW  count of delivered results with ovf=1.
- clr_cnt  in  1  synchronous clear of ovf_cnt.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; there SHALL be no other clock or asynchronous reset.

Function
REQ-005 The block SHALL be a 2-stage pipeline: S1 registers a, b, op, sgn, sat; S2 registers y, cout, ovf.
REQ-006 An input transfer SHALL occur when in_valid=1 and in_ready=1; an output transfer when out_valid=1 and out_ready=1.
REQ-007 S2 SHALL advance (load from S1 or become empty) when S2 is empty or out_ready=1.
REQ-008 S1 SHALL advance when S1 is empty or S2 advances.
REQ-009 in_ready SHALL equal (S1 empty) OR (S2 empty) OR out_ready, combinationally.
REQ-010 Latency SHALL be 2 cycles from input transfer to out_valid with no backpressure; throughput SHALL be one result per cycle.
REQ-011 Under backpressure, results SHALL be held stable (y, cout, ovf, out_valid unchanged) until transferred; no result SHALL be lost, duplicated or reordered.
REQ-012 Raw result SHALL be computed on W+1 bits: add = a+b; sub = a + ~b + 1. y_raw = low W bits.
REQ-013 cout SHALL be bit W of the add sum; for sub, cout SHALL be the inverse of bit W (borrow).
REQ-014 ovf with sgn=0 SHALL equal cout; with sgn=1 SHALL be 1 when operand signs (after b inversion for sub) match and y_raw sign differs.
REQ-015 With sat=0, y SHALL be y_raw.
REQ-016 With sat=1 and ovf=1:
- unsigned add: y = all ones.
- unsigned sub: y = 0.
- signed positive overflow: y = 0x7F..F.
- signed negative overflow: y = 0x80..0.
REQ-017 With sat=1 and ovf=0, y SHALL be y_raw; cout and ovf SHALL always reflect the raw operation.
REQ-018 ovf_cnt SHALL increment by 1 on each output transfer with ovf=1 and SHALL saturate at 2^CW-1 (no wrap).
REQ-019 clr_cnt=1 SHALL set ovf_cnt to 0 next cycle, overriding a simultaneous increment.
REQ-020 Mode inputs (op, sgn, sat) SHALL be sampled per operand set at input transfer; changes do not affect in-flight results.

Reset
REQ-021 While rst=1 at a rising edge: S1 and S2 SHALL become empty; out_valid=0, y=0, cout=0, ovf=0, ovf_cnt=0.
REQ-022 Reset mid-operation SHALL discard all in-flight results; no output transfer SHALL occur in the cycle following reset.
REQ-023 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (W=16, CW=8)
REQ-024 a=0xFFFF, b=0x0001, op=0, sgn=0: sat=0 -> y=0x0000, cout=1, ovf=1; sat=1 -> y=0xFFFF, cout=1, ovf=1; both with out_valid 2 cycles after transfer.
REQ-025 a=0x7FFF, b=0x0001, op=0, sgn=1: sat=0 -> y=0x8000, ovf=1, cout=0; sat=1 -> y=0x7FFF. a=0x8000, b=0x0001, op=1, sgn=1, sat=1 -> y=0x8000, ovf=1.
REQ-026 a=0x0003, b=0x0005, op=1, sgn=0: sat=0 -> y=0xFFFE, cout=1, ovf=1; sat=1 -> y=0x0000. a=0x0005, b=0x0003 -> y=0x0002, cout=0, ovf=0.
REQ-027 out_ready=0 with in_valid=1 and 4 distinct sets offered -> exactly 2 accepted, then in_ready=0; out_ready=1 -> results emerge in order, one per cycle, values unchanged while held.
REQ-028 260 consecutive overflowing results -> ovf_cnt stops at 0xFF; clr_cnt=1 together with an overflowing transfer -> ovf_cnt=0x00.
REQ-029 rst=1 with both stages full and out_ready=0 -> next cycle out_valid=0, ovf_cnt=0, in_ready=1; no stale result appears afterwards.
